signal_conv_encoder: RTL and testbench

Serialises and convolutionally encodes the 24-bit PLCP SIGNAL field (RATE, reserved, LENGTH, parity, tail) into 48 coded bits for the BPSK 6 Mb/s SIGNAL OFDM symbol.
- Encoder is the 802.11a rate-1/2, K=7 code, generators g0=133₈ and g1=171₈. No puncturing. No scrambling.
- Sits directly downstream of the SIGNAL-field builder and upstream of the SIGNAL interleaver/BPSK mapper.
- Emits one coded pair {A,B} per handshake under a valid/ready protocol.

---
 rtl/signal_enc_pkg.sv | 18 +
 rtl/conv_encoder_k7.sv | 31 +++
 rtl/signal_conv_encoder.sv | 87 ++++++++
 tb/tb_signal_conv_encoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/signal_enc_pkg.sv
// Shared constants and types for the SIGNAL-field convolutional encoder.
// The generator constants are also used by the DATA-field encoder.
package signal_enc_pkg;

  localparam int SIGNAL_BITS = 24;
  localparam int TAIL_BITS   = 6;
  localparam int CNT_W       = 5;

  // Bit 6 of each generator taps the current input, bit 0 the oldest history bit.
  localparam logic [6:0] G0 = 7'o133;
  localparam logic [6:0] G1 = 7'o171;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/conv_encoder_k7.sv
// Rate-1/2, K=7 convolutional encoder core: 6-bit history with enable and clear.
// The coded pair {A,B} is combinational from the current bit and the history.
module conv_encoder_k7
  import signal_enc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [1:0] o_pair
);

  logic [6:1] r_hist;
  logic [6:0] w_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (i_clr) begin
      r_hist <= '0;
    end else if (i_en) begin
      r_hist <= {r_hist[5:1], i_bit};
    end
  end

  // Window ordered to line up with the generator masks: current bit at the MSB.
  assign w_win  = {i_bit, r_hist[1], r_hist[2], r_hist[3], r_hist[4], r_hist[5], r_hist[6]};
  assign o_pair = {^(w_win & G0), ^(w_win & G1)};

endmodule

// File: rtl/signal_conv_encoder.sv
// Serialises the 24-bit SIGNAL field MSB first and emits 24 coded pairs
// through a valid/ready handshake; tail and parity problems are flagged only.
module signal_conv_encoder
  import signal_enc_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SIGNAL_BITS-1:0] signal_in,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [1:0]             out_bits,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   tail_err,
  output logic                   parity_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SIGNAL_BITS - 1);

  state_t                 r_state;
  state_t                 w_state_next;
  logic [SIGNAL_BITS-1:0] r_sr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_tail_err;
  logic                   r_parity_err;
  logic                   w_busy;
  logic                   w_accept;
  logic                   w_fire;
  logic [1:0]             w_pair;

  assign w_busy   = (r_state == BUSY);
  assign w_accept = !w_busy && in_valid;
  assign w_fire   = w_busy && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = BUSY;
      BUSY:    if (out_ready && (r_cnt == LAST_IDX)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr         <= '0;
      r_cnt        <= '0;
      r_tail_err   <= 1'b0;
      r_parity_err <= 1'b0;
    end else if (w_accept) begin
      r_sr         <= signal_in;
      r_cnt        <= '0;
      r_tail_err   <= |signal_in[TAIL_BITS-1:0];
      r_parity_err <= ^signal_in[SIGNAL_BITS-1:TAIL_BITS];
    end else if (w_fire) begin
      r_sr         <= {r_sr[SIGNAL_BITS-2:0], 1'b0};
      r_cnt        <= r_cnt + 1'b1;
    end
  end

  // History is cleared on accept so every frame starts from the all-zero state.
  conv_encoder_k7 u_enc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (w_fire),
    .i_bit  (r_sr[SIGNAL_BITS-1]),
    .o_pair (w_pair)
  );

  assign in_ready   = !w_busy;
  assign out_valid  = w_busy;
  assign out_bits   = w_busy ? w_pair : 2'b00;
  assign out_last   = w_busy && (r_cnt == LAST_IDX);
  assign tail_err   = r_tail_err;
  assign parity_err = r_parity_err;

endmodule

// File: tb/tb_signal_conv_encoder.sv
// Scoreboard bench for signal_conv_encoder: stimulus pushes expected pairs,
// a negedge monitor pops and compares every accepted pair.
module tb_signal_conv_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] signal_in;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_bits;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        tail_err;
  logic        parity_err;

  typedef struct packed {
    logic [1:0] bits;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_pairs = 0;

  always #5 clk = ~clk;

  signal_conv_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .signal_in  (signal_in),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_bits   (out_bits),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .tail_err   (tail_err),
    .parity_err (parity_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference encoder written directly from the generator definitions.
  function automatic void ref_pairs(input logic [23:0] f, output logic [1:0] p[24]);
    logic [6:0] g0;
    logic [6:0] g1;
    logic [6:0] d;
    logic       a;
    logic       b;
    g0 = 7'o133;
    g1 = 7'o171;
    d  = '0;
    for (int t = 0; t < 24; t++) begin
      d = {d[5:0], f[23-t]};
      a = 1'b0;
      b = 1'b0;
      for (int k = 0; k < 7; k++) begin
        if (g0[6-k]) a = a ^ d[k];
        if (g1[6-k]) b = b ^ d[k];
      end
      p[t] = {a, b};
    end
  endfunction

  // Monitor: one compare per handshake, plus stall stability and idle zeroing.
  logic       stall_prev = 1'b0;
  logic [1:0] stall_bits = 2'b00;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (stall_prev) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_bits", 32'(out_bits), 32'(stall_bits));
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_pair", 32'(sb_q.size()), 32'd1);
      end else begin
        mon_e = sb_q.pop_front();
        n_pairs++;
        $display("pair %0d: bits=%b last=%b (expected bits=%b last=%b)",
                 n_pairs, out_bits, out_last, mon_e.bits, mon_e.last);
        chk("pair_bits", 32'(out_bits), 32'(mon_e.bits));
        chk("pair_last", 32'(out_last), 32'(mon_e.last));
      end
    end else if (!out_valid) begin
      chk("idle_zero", 32'({out_bits, out_last}), 32'd0);
    end
    stall_prev = out_valid && !out_ready;
    stall_bits = out_bits;
  end

  task automatic run_frame(input logic [23:0] f, input logic [1:0] p[24],
                           input logic et, input logic ep,
                           input bit stall, input int abort_at);
    logic rp[4];
    int   cyc;
    bit   done;
    bit   aborted;
    rp = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 24; i++) sb_q.push_back('{bits: p[i], last: (i == 23)});
    @(posedge clk); #1;
    signal_in = f;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    signal_in = '0;
    cyc     = 1;
    done    = 1'b0;
    aborted = 1'b0;
    while (!done && cyc < 200) begin
      if (abort_at != 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_flags", 32'({tail_err, parity_err}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        aborted = 1'b1;
        done    = 1'b1;
      end else begin
        out_ready = stall ? rp[(cyc-1)%4] : 1'b1;
        // A field offered mid-frame must be ignored.
        in_valid  = (cyc == 5);
        signal_in = (cyc == 5) ? 24'hFFFFFF : 24'h000000;
        @(negedge clk);
        if (cyc == 1) begin
          chk("tail_err", 32'(tail_err), 32'(et));
          chk("parity_err", 32'(parity_err), 32'(ep));
        end
        if (in_ready) done = 1'b1;
        else begin
          @(posedge clk); #1;
          cyc++;
        end
      end
    end
    chk("frame_done", 32'(done), 32'd1);
    if (!stall && !aborted) chk("frame_cycles", 32'(cyc), 32'd25);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    $display("frame %h: stall=%0d abort=%0d ready after %0d cycles", f, stall, aborted, cyc);
  endtask

  logic [1:0] zero_p[24];
  logic [1:0] imp_p[24];
  logic [1:0] tail_p[24];
  logic [1:0] gold_p[24];

  initial begin
    rst_n     = 1'b0;
    signal_in = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    zero_p = '{default: 2'b00};
    imp_p  = '{default: 2'b00};
    imp_p[0] = 2'b11; imp_p[1] = 2'b01; imp_p[2] = 2'b11; imp_p[3] = 2'b11;
    imp_p[4] = 2'b00; imp_p[5] = 2'b10; imp_p[6] = 2'b11;
    tail_p = '{default: 2'b00};
    tail_p[23] = 2'b11;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_flags", 32'({tail_err, parity_err}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_frame(24'h000000, zero_p, 1'b0, 1'b0, 1'b0, 0);
    run_frame(24'h800000, imp_p,  1'b0, 1'b1, 1'b0, 0);
    // 6 Mb/s, LENGTH=100, even parity, zero tail.
    ref_pairs(24'hD13000, gold_p);
    run_frame(24'hD13000, gold_p, 1'b0, 1'b0, 1'b0, 0);
    run_frame(24'hD13000, gold_p, 1'b0, 1'b0, 1'b1, 0);
    // Nonzero tail bits and odd parity over bits 23:6: both flags set.
    ref_pairs(24'hD0C018, gold_p);
    run_frame(24'hD0C018, gold_p, 1'b1, 1'b1, 1'b0, 0);
    run_frame(24'h000001, tail_p, 1'b1, 1'b0, 1'b0, 0);
    run_frame(24'h800000, imp_p,  1'b0, 1'b1, 1'b0, 10);
    run_frame(24'h800000, imp_p,  1'b0, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
